// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioning logic.
package btn_pkg;

  // Debounce FSM states: settled low, qualifying a rise, settled high, qualifying a fall.
  typedef enum logic [1:0] {
    S_LOW,
    S_CHK_HIGH,
    S_HIGH,
    S_CHK_LOW
  } btn_state_t;

  // 10 ms stability window at 100 MHz.
  localparam int unsigned BTN_DEBOUNCE_DEFAULT = 1_000_000;

  // 1 s hold time at 100 MHz before a long press is reported.
  localparam int unsigned BTN_LONG_DEFAULT = 100_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous board inputs (buttons, switches).
// Both stages clear immediately on the asynchronous active-high reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  // Two back-to-back flops give metastability a full cycle to resolve before q is used.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, 4-state debounce FSM with a stability
// counter, registered level output and one-cycle rise/fall pulses.
// Optional feature: define BTN_LONG_PRESS_EN to build the hold counter that drives
// long_press; without it long_press is tied to 0 and no hold counter exists.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = BTN_DEBOUNCE_DEFAULT,
  parameter int unsigned LONG_PRESS_CYCLES = BTN_LONG_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic long_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Both windows must be at least one cycle long for the counters to make sense.
  if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1) begin : g_param_check
    $error("btn_debounce: DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must be >= 1");
  end

  logic             btn_sync;
  btn_state_t       state;
  btn_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             level_next;
  logic             rise_next;
  logic             fall_next;

  sync_2ff #(
    .WIDTH(1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_in),
    .q    (btn_sync)
  );

  // State and stability counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_LOW;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: any reversal during a check aborts it, and the counter exits at
  // CNT_LAST so it never wraps.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_LOW: begin
        if (btn_sync) begin
          state_next = S_CHK_HIGH;
          cnt_next   = '0;
        end
      end
      S_CHK_HIGH: begin
        if (!btn_sync) begin
          state_next = S_LOW;
        end else if (cnt == CNT_LAST) begin
          state_next = S_HIGH;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_HIGH: begin
        if (!btn_sync) begin
          state_next = S_CHK_LOW;
          cnt_next   = '0;
        end
      end
      S_CHK_LOW: begin
        if (btn_sync) begin
          state_next = S_HIGH;
        end else if (cnt == CNT_LAST) begin
          state_next = S_LOW;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = S_LOW;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode: level follows the settled side, pulses only on completed qualifications.
  always_comb begin
    level_next = (state_next == S_HIGH) || (state_next == S_CHK_LOW);
    rise_next  = (state == S_CHK_HIGH) && (state_next == S_HIGH);
    fall_next  = (state == S_CHK_LOW) && (state_next == S_LOW);
  end

  // Registered outputs so downstream logic sees glitch-free, single-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
    end else begin
      btn_level <= level_next;
      btn_rise  <= rise_next;
      btn_fall  <= fall_next;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_PRESS_CYCLES);

  logic [HOLD_W-1:0] hold;

  // Hold counter: restarts on each accepted press, saturates one past the trigger
  // point so long_press fires once per press, and clears when the press ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold       <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (rise_next || state_next == S_LOW) begin
        hold <= '0;
      end else if ((state == S_HIGH || state == S_CHK_LOW) && hold != HOLD_SAT) begin
        hold       <= hold + 1'b1;
        long_press <= (hold == HOLD_LAST);
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=8.
// Compares every cycle against a run-length reference model of the debouncer.
module tb_btn_debounce;

  localparam int D = 4;
  localparam int L = 8;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;
  logic long_press;

  int checks = 0;
  int failures = 0;

  // Reference model state: raw samples in flight through the synchronizer, length of
  // the current run of samples disagreeing with the level, and cycles since the rise.
  logic pipe1, pipe2;
  int   run_len;
  int   since_rise;
  logic m_level, m_rise, m_fall, m_long;

  int rise_seen, fall_seen, long_seen;
  int lat;

  btn_debounce #(
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .long_press(long_press)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelClear();
    pipe1      = 1'b0;
    pipe2      = 1'b0;
    run_len    = 0;
    since_rise = 0;
    m_level    = 1'b0;
    m_rise     = 1'b0;
    m_fall     = 1'b0;
    m_long     = 1'b0;
  endtask

  // One clock edge: the debounced level flips once D+1 consecutive synced samples
  // disagree with it; a long press is reported L cycles after the rise.
  task automatic modelEdge(input logic b);
    logic seen;
    seen   = pipe2;
    pipe2  = pipe1;
    pipe1  = b;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_long = 1'b0;
    if (seen != m_level) begin
      run_len++;
      if (run_len == D + 1) begin
        m_level = seen;
        run_len = 0;
        if (seen) begin
          m_rise     = 1'b1;
          since_rise = 0;
        end else begin
          m_fall = 1'b1;
        end
      end
    end else begin
      run_len = 0;
    end
    if (m_level && !m_rise) begin
      since_rise++;
`ifdef BTN_LONG_PRESS_EN
      if (since_rise == L) m_long = 1'b1;
`endif
    end
  endtask

  task automatic compareAll();
    checkOutput("btn_level", btn_level, m_level);
    checkOutput("btn_rise", btn_rise, m_rise);
    checkOutput("btn_fall", btn_fall, m_fall);
    checkOutput("long_press", long_press, m_long);
    if (btn_rise) rise_seen++;
    if (btn_fall) fall_seen++;
    if (long_press) long_seen++;
  endtask

  task automatic applyStimulus(input logic b);
    btn_in = b;
    @(posedge clk);
    modelEdge(b);
    #1;
    compareAll();
  endtask

  task automatic holdCount(input logic b, input int n);
    for (int i = 0; i < n; i++) applyStimulus(b);
  endtask

  task automatic doReset();
    reset = 1'b1;
    modelClear();
    #1;
    compareAll();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Drives 1 until btn_rise appears; returns the number of edges taken, or -1 on timeout.
  task automatic measureRise(output int edges, input int budget);
    edges = -1;
    for (int i = 1; i <= budget; i++) begin
      applyStimulus(1'b1);
      if (btn_rise) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin
    reset  = 1'b0;
    btn_in = 1'b0;
    modelClear();
    rise_seen = 0;
    fall_seen = 0;
    long_seen = 0;
    #2;
    doReset();

    // Clean press: s1 captures on the first edge, rise lands D+2 edges later.
    measureRise(lat, 20);
    checkOutput("rise_latency", lat, D + 3);
    holdCount(1'b1, 3);
    holdCount(1'b0, 10);

    // Fast bounce never qualifies.
    rise_seen = 0;
    fall_seen = 0;
    for (int i = 0; i < 6; i++) applyStimulus(1'(i % 2 == 0));
    holdCount(1'b0, 10);
    checkOutput("bounce_rise_count", rise_seen, 0);
    checkOutput("bounce_fall_count", fall_seen, 0);

    // Short dropout while high is rejected, then a real release falls once.
    holdCount(1'b1, 10);
    fall_seen = 0;
    holdCount(1'b0, 3);
    holdCount(1'b1, 6);
    checkOutput("dropout_fall_count", fall_seen, 0);
    checkOutput("dropout_level", btn_level, 1);
    holdCount(1'b0, 4);
    holdCount(1'b1, 6);
    checkOutput("last_count_abort_fall", fall_seen, 0);
    holdCount(1'b0, 10);
    checkOutput("release_fall_count", fall_seen, 1);
    checkOutput("release_level", btn_level, 0);

    // Reset in the middle of a rise check, then re-qualify from scratch.
    holdCount(1'b1, 5);
    doReset();
    checkOutput("reset_mid_check_level", btn_level, 0);
    measureRise(lat, 20);
    checkOutput("requalify_latency", lat, D + 3);

    // Long press: one pulse per press when enabled, never otherwise.
    holdCount(1'b0, 10);
    long_seen = 0;
    holdCount(1'b1, 30);
`ifdef BTN_LONG_PRESS_EN
    checkOutput("long_count_first", long_seen, 1);
`else
    checkOutput("long_count_first", long_seen, 0);
`endif
    holdCount(1'b0, 10);
    long_seen = 0;
    holdCount(1'b1, 30);
`ifdef BTN_LONG_PRESS_EN
    checkOutput("long_count_second", long_seen, 1);
`else
    checkOutput("long_count_second", long_seen, 0);
`endif

    // Random bursts of varying length with occasional resets.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        doReset();
      end else begin
        holdCount(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
